// File: rtl/pe_pass_sched_pkg.sv
// Shared types for the pass scheduler: datapath command word and scheduler state/config.
package PECfg;
  typedef struct packed {
    logic dval;
    logic start;
    logic reset;
    logic stall;
  } Inst;
endpackage

package PECtlCfg;
  localparam int NPASS_W_DEF = 8;
  localparam int NOUT_W_DEF  = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    RUN   = 3'd2,
    STALL = 3'd3,
    DRAIN = 3'd4
  } SchedState;
endpackage

// File: rtl/pe_pass_sched_if.sv
// Bundle of the scheduler's job, MAIN-monitor, psum and drain signals, with both-side views.
interface pe_pass_sched_if #(
  parameter int NPASS_W = PECtlCfg::NPASS_W_DEF,
  parameter int NOUT_W  = PECtlCfg::NOUT_W_DEF
) ();
  import PECfg::*;

  logic               Cmd_rdy;
  logic               Cmd_ack;
  logic [NPASS_W-1:0] i_npass;
  logic [NOUT_W-1:0]  i_nout;
  logic               i_MAIN_rdy;
  logic               i_MAIN_ack;
  logic               i_psum_full;
  logic               i_abort;
  Inst                o_PEinst;
  logic               Drain_rdy;
  logic               Drain_ack;
  logic [NPASS_W-1:0] o_pass_idx;
  logic               o_busy;
  logic               o_done;

  modport master (
    input  Cmd_rdy, i_npass, i_nout, i_MAIN_rdy, i_MAIN_ack, i_psum_full, i_abort, Drain_ack,
    output Cmd_ack, o_PEinst, Drain_rdy, o_pass_idx, o_busy, o_done
  );

  modport slave (
    output Cmd_rdy, i_npass, i_nout, i_MAIN_rdy, i_MAIN_ack, i_psum_full, i_abort, Drain_ack,
    input  Cmd_ack, o_PEinst, Drain_rdy, o_pass_idx, o_busy, o_done
  );
endinterface

// File: rtl/pe_pass_sched_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
endmodule

// File: rtl/pe_pass_sched.sv
// Multi-pass job scheduler for the PE datapath controller.
// Define PE_SCHED_PERF_EN to add the o_stall_cycles STALL-state counter.
module pe_pass_sched
  import PECfg::*;
  import PECtlCfg::*;
#(
  parameter int NPASS_W = NPASS_W_DEF,
  parameter int NOUT_W  = NOUT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Cmd_rdy,
  output logic               Cmd_ack,
  input  logic [NPASS_W-1:0] i_npass,
  input  logic [NOUT_W-1:0]  i_nout,
  input  logic               i_MAIN_rdy,
  input  logic               i_MAIN_ack,
  input  logic               i_psum_full,
  input  logic               i_abort,
  output Inst                o_PEinst,
  output logic               Drain_rdy,
  input  logic               Drain_ack,
  output logic [NPASS_W-1:0] o_pass_idx,
  output logic               o_busy,
  output logic               o_done
`ifdef PE_SCHED_PERF_EN
  ,
  output logic [15:0]        o_stall_cycles
`endif
);
  localparam logic [NPASS_W-1:0] PASS_ONE = 1;

  SchedState          state_q, state_d;
  logic [NPASS_W-1:0] npass_q, npass_d;
  logic [NPASS_W-1:0] pass_idx_q, pass_idx_d;
  logic [NOUT_W-1:0]  nout_q, nout_d;
  logic [NOUT_W-1:0]  cnt_q, cnt_d;
  logic               done_q, done_d;
  Inst                inst_c;

  logic              main_hs;
  logic [NOUT_W:0]   cnt_sum;
  logic              pass_done;
  logic              last_pass;

  assign main_hs   = i_MAIN_rdy && i_MAIN_ack;
  // One extra bit so a wrapped count can never alias a small nout.
  assign cnt_sum   = {1'b0, cnt_q} + {{NOUT_W{1'b0}}, main_hs};
  assign pass_done = (nout_q == '0) || (cnt_sum == {1'b0, nout_q});
  assign last_pass = (pass_idx_q == (npass_q - PASS_ONE));

  always_comb begin
    state_d    = state_q;
    npass_d    = npass_q;
    nout_d     = nout_q;
    cnt_d      = cnt_q;
    pass_idx_d = pass_idx_q;
    done_d     = 1'b0;
    inst_c     = '0;

    case (state_q)
      IDLE: begin
        if (Cmd_rdy) begin
          if (i_npass == '0) begin
            done_d = 1'b1;
          end else begin
            npass_d    = i_npass;
            nout_d     = i_nout;
            pass_idx_d = '0;
            state_d    = START;
          end
        end
      end

      START: begin
        if (i_abort) begin
          inst_c.dval  = 1'b1;
          inst_c.reset = 1'b1;
          state_d      = IDLE;
        end else begin
          inst_c.dval  = 1'b1;
          inst_c.start = 1'b1;
          cnt_d        = '0;
          state_d      = RUN;
        end
      end

      RUN, STALL: begin
        if (main_hs) cnt_d = cnt_sum[NOUT_W-1:0];
        // Abort beats completion, completion beats stall/unstall.
        if (i_abort) begin
          inst_c.dval  = 1'b1;
          inst_c.reset = 1'b1;
          state_d      = IDLE;
        end else if (pass_done) begin
          inst_c.dval  = 1'b1;
          inst_c.reset = 1'b1;
          state_d      = DRAIN;
        end else if ((state_q == RUN) && i_psum_full) begin
          inst_c.dval  = 1'b1;
          inst_c.stall = 1'b1;
          state_d      = STALL;
        end else if ((state_q == STALL) && !i_psum_full) begin
          inst_c.dval  = 1'b1;
          state_d      = RUN;
        end
      end

      DRAIN: begin
        if (i_abort) begin
          inst_c.dval  = 1'b1;
          inst_c.reset = 1'b1;
          state_d      = IDLE;
        end else if (Drain_ack) begin
          if (last_pass) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            pass_idx_d = pass_idx_q + PASS_ONE;
            state_d    = START;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      npass_q    <= '0;
      nout_q     <= '0;
      cnt_q      <= '0;
      pass_idx_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      npass_q    <= npass_d;
      nout_q     <= nout_d;
      cnt_q      <= cnt_d;
      pass_idx_q <= pass_idx_d;
      done_q     <= done_d;
    end
  end

  // A reset mid-job must not leak an abort-style reset command to the datapath.
  assign o_PEinst   = rst ? '0 : inst_c;
  assign Cmd_ack    = (state_q == IDLE);
  assign Drain_rdy  = (state_q == DRAIN);
  assign o_busy     = (state_q != IDLE);
  assign o_pass_idx = pass_idx_q;
  assign o_done     = done_q;

`ifdef PE_SCHED_PERF_EN
  sat_counter #(.W(16)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (Cmd_rdy && (state_q == IDLE)),
    .inc   (state_q == STALL),
    .count (o_stall_cycles)
  );
`endif
endmodule

// File: tb/tb_pe_pass_sched.sv
// Directed bench for pe_pass_sched; build with PE_SCHED_PERF_EN to also check o_stall_cycles.
module tb_pe_pass_sched;
  import PECfg::*;

  localparam int NPASS_W = 8;
  localparam int NOUT_W  = 16;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pe_pass_sched_if #(.NPASS_W(NPASS_W), .NOUT_W(NOUT_W)) bus ();

`ifdef PE_SCHED_PERF_EN
  logic [15:0] stall_cycles;
`endif

  pe_pass_sched #(.NPASS_W(NPASS_W), .NOUT_W(NOUT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .Cmd_rdy     (bus.Cmd_rdy),
    .Cmd_ack     (bus.Cmd_ack),
    .i_npass     (bus.i_npass),
    .i_nout      (bus.i_nout),
    .i_MAIN_rdy  (bus.i_MAIN_rdy),
    .i_MAIN_ack  (bus.i_MAIN_ack),
    .i_psum_full (bus.i_psum_full),
    .i_abort     (bus.i_abort),
    .o_PEinst    (bus.o_PEinst),
    .Drain_rdy   (bus.Drain_rdy),
    .Drain_ack   (bus.Drain_ack),
    .o_pass_idx  (bus.o_pass_idx),
    .o_busy      (bus.o_busy),
    .o_done      (bus.o_done)
`ifdef PE_SCHED_PERF_EN
    ,
    .o_stall_cycles (stall_cycles)
`endif
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [NPASS_W-1:0] np, input logic [NOUT_W-1:0] no);
    bus.Cmd_rdy = 1'b1; bus.i_npass = np; bus.i_nout = no;
    #1;
    checks++; if (bus.Cmd_ack !== 1'b1) begin failures++; $display("FAIL cmd_ack_idle: got %b want 1", bus.Cmd_ack); end
    cyc();
    bus.Cmd_rdy = 1'b0;
    $display("job accepted npass=%0d nout=%0d", np, no);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.Cmd_rdy = 1'b0; bus.i_npass = '0; bus.i_nout = '0;
    bus.i_MAIN_rdy = 1'b0; bus.i_MAIN_ack = 1'b0; bus.i_psum_full = 1'b0;
    bus.i_abort = 1'b0; bus.Drain_ack = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    #1;
    checks++; if (bus.o_PEinst !== 4'b0000) begin failures++; $display("FAIL rst_inst: got %b want 0000", bus.o_PEinst); end
    checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", bus.o_busy); end
    checks++; if (bus.o_done !== 1'b0) begin failures++; $display("FAIL rst_done: got %b want 0", bus.o_done); end
    checks++; if (bus.Drain_rdy !== 1'b0) begin failures++; $display("FAIL rst_drain_rdy: got %b want 0", bus.Drain_rdy); end
    checks++; if (bus.o_pass_idx !== 8'd0) begin failures++; $display("FAIL rst_pass_idx: got %0d want 0", bus.o_pass_idx); end
    checks++; if (bus.Cmd_ack !== 1'b1) begin failures++; $display("FAIL rst_cmd_ack: got %b want 1", bus.Cmd_ack); end
`ifdef PE_SCHED_PERF_EN
    checks++; if (stall_cycles !== 16'd0) begin failures++; $display("FAIL rst_stall_cycles: got %0d want 0", stall_cycles); end
`endif
    $display("reset released");
  endtask

  task automatic test_two_pass();
    logic [3:0] exp_inst;
    start_job(8'd2, 16'd3);
    for (int p = 0; p < 2; p++) begin
      #1;
      checks++; if (bus.o_PEinst !== 4'b1100) begin failures++; $display("FAIL tp_start_cmd: got %b want 1100", bus.o_PEinst); end
      checks++; if (bus.o_pass_idx !== 8'(p)) begin failures++; $display("FAIL tp_pass_idx: got %0d want %0d", bus.o_pass_idx, p); end
      checks++; if (bus.o_done !== 1'b0) begin failures++; $display("FAIL tp_early_done: got %b want 0", bus.o_done); end
      checks++; if (bus.Cmd_ack !== 1'b0) begin failures++; $display("FAIL tp_cmd_ack_busy: got %b want 0", bus.Cmd_ack); end
      cyc();
      for (int k = 0; k < 3; k++) begin
        bus.i_MAIN_rdy = 1'b1; bus.i_MAIN_ack = 1'b1;
        #1;
        exp_inst = (k == 2) ? 4'b1010 : 4'b0000;
        checks++; if (bus.o_PEinst !== exp_inst) begin failures++; $display("FAIL tp_main_%0d: got %b want %b", k, bus.o_PEinst, exp_inst); end
        cyc();
      end
      bus.i_MAIN_rdy = 1'b0; bus.i_MAIN_ack = 1'b0;
      #1;
      checks++; if (bus.Drain_rdy !== 1'b1) begin failures++; $display("FAIL tp_drain_rdy: got %b want 1", bus.Drain_rdy); end
      checks++; if (bus.o_PEinst !== 4'b0000) begin failures++; $display("FAIL tp_drain_inst: got %b want 0000", bus.o_PEinst); end
      cyc();
      checks++; if (bus.Drain_rdy !== 1'b1) begin failures++; $display("FAIL tp_drain_hold: got %b want 1", bus.Drain_rdy); end
      bus.Drain_ack = 1'b1;
      cyc();
      bus.Drain_ack = 1'b0;
      $display("pass %0d drained", p);
    end
    #1;
    checks++; if (bus.o_done !== 1'b1) begin failures++; $display("FAIL tp_done: got %b want 1", bus.o_done); end
    checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL tp_busy_end: got %b want 0", bus.o_busy); end
    cyc();
    checks++; if (bus.o_done !== 1'b0) begin failures++; $display("FAIL tp_done_pulse: got %b want 0", bus.o_done); end
  endtask

  task automatic test_stall();
    start_job(8'd1, 16'd4);
    cyc();
    bus.i_MAIN_rdy = 1'b1; bus.i_MAIN_ack = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (bus.o_PEinst !== 4'b0000) begin failures++; $display("FAIL st_pre_main_%0d: got %b want 0000", k, bus.o_PEinst); end
      cyc();
    end
    bus.i_MAIN_rdy = 1'b0; bus.i_MAIN_ack = 1'b0; bus.i_psum_full = 1'b1;
    #1;
    checks++; if (bus.o_PEinst !== 4'b1001) begin failures++; $display("FAIL st_stall_cmd: got %b want 1001", bus.o_PEinst); end
    cyc();
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (bus.o_PEinst !== 4'b0000) begin failures++; $display("FAIL st_hold_%0d: got %b want 0000", k, bus.o_PEinst); end
      cyc();
    end
    bus.i_psum_full = 1'b0;
    #1;
    checks++; if (bus.o_PEinst !== 4'b1000) begin failures++; $display("FAIL st_unstall_cmd: got %b want 1000", bus.o_PEinst); end
    cyc();
`ifdef PE_SCHED_PERF_EN
    checks++; if (stall_cycles !== 16'd5) begin failures++; $display("FAIL st_stall_cycles: got %0d want 5", stall_cycles); end
`endif
    bus.i_MAIN_rdy = 1'b1; bus.i_MAIN_ack = 1'b1;
    #1;
    checks++; if (bus.o_PEinst !== 4'b0000) begin failures++; $display("FAIL st_third_main: got %b want 0000", bus.o_PEinst); end
    cyc();
    checks++; if (bus.o_PEinst !== 4'b1010) begin failures++; $display("FAIL st_count_kept: got %b want 1010", bus.o_PEinst); end
    cyc();
    bus.i_MAIN_rdy = 1'b0; bus.i_MAIN_ack = 1'b0; bus.Drain_ack = 1'b1;
    cyc();
    bus.Drain_ack = 1'b0;
    checks++; if (bus.o_done !== 1'b1) begin failures++; $display("FAIL st_done: got %b want 1", bus.o_done); end
    cyc();
    $display("stall job finished");
  endtask

  task automatic test_complete_vs_stall();
    start_job(8'd1, 16'd2);
    cyc();
    bus.i_MAIN_rdy = 1'b1; bus.i_MAIN_ack = 1'b1;
    cyc();
    bus.i_psum_full = 1'b1;
    #1;
    checks++; if (bus.o_PEinst !== 4'b1010) begin failures++; $display("FAIL cs_reset_cmd: got %b want 1010", bus.o_PEinst); end
    cyc();
    bus.i_MAIN_rdy = 1'b0; bus.i_MAIN_ack = 1'b0;
    #1;
    checks++; if (bus.Drain_rdy !== 1'b1) begin failures++; $display("FAIL cs_drain: got %b want 1", bus.Drain_rdy); end
    checks++; if (bus.o_PEinst !== 4'b0000) begin failures++; $display("FAIL cs_no_stall: got %b want 0000", bus.o_PEinst); end
    bus.Drain_ack = 1'b1; bus.i_psum_full = 1'b0;
    cyc();
    bus.Drain_ack = 1'b0;
    checks++; if (bus.o_done !== 1'b1) begin failures++; $display("FAIL cs_done: got %b want 1", bus.o_done); end
    cyc();
    $display("completion-over-stall job finished");
  endtask

  task automatic test_abort_stall();
    start_job(8'd1, 16'd5);
    cyc();
    bus.i_psum_full = 1'b1;
    cyc();
    bus.i_abort = 1'b1;
    #1;
    checks++; if (bus.o_PEinst !== 4'b1010) begin failures++; $display("FAIL ab_reset_cmd: got %b want 1010", bus.o_PEinst); end
    cyc();
    bus.i_abort = 1'b0; bus.i_psum_full = 1'b0;
    #1;
    checks++; if (bus.Cmd_ack !== 1'b1) begin failures++; $display("FAIL ab_cmd_ack: got %b want 1", bus.Cmd_ack); end
    checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL ab_busy: got %b want 0", bus.o_busy); end
    checks++; if (bus.o_done !== 1'b0) begin failures++; $display("FAIL ab_done: got %b want 0", bus.o_done); end
    cyc();
    checks++; if (bus.o_done !== 1'b0) begin failures++; $display("FAIL ab_done_late: got %b want 0", bus.o_done); end
    $display("abort in stall handled");
  endtask

  task automatic test_npass_zero();
    bus.Cmd_rdy = 1'b1; bus.i_npass = 8'd0; bus.i_nout = 16'd7;
    #1;
    checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL nz_busy0: got %b want 0", bus.o_busy); end
    cyc();
    bus.Cmd_rdy = 1'b0;
    #1;
    checks++; if (bus.o_done !== 1'b1) begin failures++; $display("FAIL nz_done: got %b want 1", bus.o_done); end
    checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL nz_busy1: got %b want 0", bus.o_busy); end
    checks++; if (bus.o_PEinst !== 4'b0000) begin failures++; $display("FAIL nz_inst: got %b want 0000", bus.o_PEinst); end
    cyc();
    checks++; if (bus.o_done !== 1'b0) begin failures++; $display("FAIL nz_done_pulse: got %b want 0", bus.o_done); end
    checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL nz_busy2: got %b want 0", bus.o_busy); end
    $display("zero-pass job finished");
  endtask

  task automatic test_rst_drain();
    start_job(8'd2, 16'd1);
    for (int p = 0; p < 2; p++) begin
      cyc();
      bus.i_MAIN_rdy = 1'b1; bus.i_MAIN_ack = 1'b1;
      cyc();
      bus.i_MAIN_rdy = 1'b0; bus.i_MAIN_ack = 1'b0;
      if (p == 0) begin
        bus.Drain_ack = 1'b1;
        cyc();
        bus.Drain_ack = 1'b0;
      end
    end
    #1;
    checks++; if (bus.o_pass_idx !== 8'd1) begin failures++; $display("FAIL rd_pass_idx_pre: got %0d want 1", bus.o_pass_idx); end
    checks++; if (bus.Drain_rdy !== 1'b1) begin failures++; $display("FAIL rd_in_drain: got %b want 1", bus.Drain_rdy); end
    rst = 1'b1; bus.i_abort = 1'b1;
    #1;
    checks++; if (bus.o_PEinst !== 4'b0000) begin failures++; $display("FAIL rd_no_reset_cmd: got %b want 0000", bus.o_PEinst); end
    cyc();
    rst = 1'b0; bus.i_abort = 1'b0;
    #1;
    checks++; if (bus.Drain_rdy !== 1'b0) begin failures++; $display("FAIL rd_drain_rdy: got %b want 0", bus.Drain_rdy); end
    checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL rd_busy: got %b want 0", bus.o_busy); end
    checks++; if (bus.o_pass_idx !== 8'd0) begin failures++; $display("FAIL rd_pass_idx: got %0d want 0", bus.o_pass_idx); end
    checks++; if (bus.o_done !== 1'b0) begin failures++; $display("FAIL rd_done: got %b want 0", bus.o_done); end
    // Follow-up job with nout=0 completes in its first RUN cycle.
    start_job(8'd1, 16'd0);
    #1;
    checks++; if (bus.o_PEinst !== 4'b1100) begin failures++; $display("FAIL rd_new_start: got %b want 1100", bus.o_PEinst); end
    cyc();
    checks++; if (bus.o_PEinst !== 4'b1010) begin failures++; $display("FAIL rd_nout0_reset: got %b want 1010", bus.o_PEinst); end
    cyc();
    bus.Drain_ack = 1'b1;
    cyc();
    bus.Drain_ack = 1'b0;
    checks++; if (bus.o_done !== 1'b1) begin failures++; $display("FAIL rd_new_done: got %b want 1", bus.o_done); end
    cyc();
    $display("reset in drain recovered");
  endtask

  initial begin
    test_reset();
    test_two_pass();
    test_stall();
    test_complete_vs_stall();
    test_abort_stall();
    test_npass_zero();
    test_rst_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pe_pass_sched.md
PE_PASS_SCHED -- requirements
Module: pe_pass_sched

Interface
REQ-001 SHALL have parameter NPASS_W, default 8, width of the pass count and pass index.
REQ-002 SHALL have parameter NOUT_W, default 16, width of the per-pass MAIN-handshake count.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports Cmd_rdy input 1 and Cmd_ack output 1, the job command handshake; a transfer occurs when both are high.
REQ-006 SHALL have ports i_npass input NPASS_W (passes per job) and i_nout input NOUT_W (MAIN transfers per pass), both sampled on a Cmd transfer.
REQ-007 SHALL have ports i_MAIN_rdy and i_MAIN_ack, input, 1 each, monitor taps of the datapath-controller MAIN handshake.
REQ-008 SHALL have port i_psum_full, input, 1, psum-sink backpressure.
REQ-009 SHALL have port i_abort, input, 1, job abort request.
REQ-010 SHALL have port o_PEinst, output, Inst, the command to the datapath controller (dval, start, reset, stall).
REQ-011 SHALL have ports Drain_rdy output 1 and Drain_ack input 1, the end-of-pass psum drain handshake.
REQ-012 SHALL have ports o_pass_idx output NPASS_W, o_busy output 1 and o_done output 1 (one-cycle pulse).

Function
REQ-013 SHALL implement states IDLE, START, RUN, STALL, DRAIN.
REQ-014 SHALL hold Cmd_ack=1 only in IDLE.
REQ-015 SHALL, on a Cmd transfer with i_npass==0, pulse o_done in the next cycle and remain in IDLE.
REQ-016 SHALL, on a Cmd transfer with i_npass>0, latch npass/nout, clear o_pass_idx, and enter START.
REQ-017 SHALL drive o_PEinst.dval=1 only in command cycles; all other o_PEinst fields SHALL be 0 when dval=0.
REQ-018 SHALL make START last exactly 1 cycle: it issues dval=1,start=1, clears the output counter, and moves to RUN.
REQ-019 SHALL, in RUN and STALL, count cycles with i_MAIN_rdy&&i_MAIN_ack in an NOUT_W counter.
REQ-020 SHALL, when that count reaches nout, issue dval=1,reset=1 in the same cycle and move to DRAIN next cycle.
REQ-021 SHALL, in RUN with i_psum_full=1 and no completion, issue dval=1,stall=1 and move to STALL.
REQ-022 SHALL, in STALL with i_psum_full=0, issue dval=1,stall=0 and move to RUN.
REQ-023 SHALL give completion priority over stall when a completing handshake and i_psum_full coincide.
REQ-024 SHALL hold Drain_rdy=1 in DRAIN until a Drain transfer.
REQ-025 SHALL, on a Drain transfer in the last pass (o_pass_idx==npass-1), pulse o_done and go to IDLE.
REQ-026 SHALL, on a Drain transfer in any other pass, increment o_pass_idx and go to START.
REQ-027 SHALL, on i_abort in any non-IDLE state, issue dval=1,reset=1 and go to IDLE with no o_done.
REQ-028 SHALL give i_abort priority over every other transition.
REQ-029 SHALL drive o_busy=1 in every state except IDLE.
REQ-030 SHALL compare counts at full width; nout==0 SHALL complete on the first RUN cycle with no wait for a MAIN handshake.

Reset
REQ-031 SHALL, on rst, set state IDLE and clear o_PEinst, o_pass_idx, the output counter and o_done to 0.
REQ-032 SHALL, on rst, set Drain_rdy=0 and o_busy=0.
REQ-033 SHALL, on rst mid-job, issue no reset command to the datapath controller; rst overrides everything.

Configuration
REQ-034 SHALL, with PE_SCHED_PERF_EN defined, add output o_stall_cycles (16 bit, saturating) counting STALL-state cycles; it clears on rst and on each Cmd transfer.
REQ-035 SHALL, with PE_SCHED_PERF_EN undefined, omit the port and its counter, with all other behaviour unchanged.

Structure
REQ-036 SHALL place the SchedState enum and the NPASS_W/NOUT_W defaults in package PECtlCfg, and take Inst from PECfg.
REQ-037 SHALL implement the saturating perf counter as sub-module sat_counter; all else is flat.

Verification
REQ-038 SHALL test npass=2, nout=3, no backpressure -> start pulse, 3 MAIN transfers, reset pulse, Drain, repeated once, o_done at job end, o_pass_idx 0 then 1.
REQ-039 SHALL test i_psum_full high 5 cycles mid-RUN -> one stall=1 command, one stall=0 command, count preserved, o_stall_cycles==5 when PE_SCHED_PERF_EN is defined.
REQ-040 SHALL test the last MAIN transfer coinciding with i_psum_full=1 -> reset command, DRAIN, no stall command.
REQ-041 SHALL test i_abort in STALL -> reset command, IDLE next cycle, no o_done, Cmd_ack=1.
REQ-042 SHALL test i_npass=0 -> o_done one cycle later, o_busy never high.
REQ-043 SHALL test rst asserted in DRAIN -> all outputs 0 next cycle, new command accepted.
